ulpi_reg_scanner: RTL and testbench



---
 rtl/ulpi_reg_scanner.sv | 175 +++++++++++++++++
 tb/tb_ulpi_reg_scanner.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_scanner.sv
// ULPI register poller: periodically reads a list of PHY registers through the ulpi_wrapper
// register port into a readable bank, services one-shot writes and tracks ack timeouts.
module ulpi_reg_scanner #(
   parameter int unsigned  NUM_REGS  = 4,
   parameter logic [127:0] ADDR_LIST = 128'h0000_0000_0A07_0504,
   parameter int unsigned  PERIOD    = 6000000,
   parameter int unsigned  TIMEOUT   = 255,
   parameter int unsigned  SEL_W     = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             scan_now_i,
   input  logic             wr_req_i,
   input  logic [7:0]       wr_addr_i,
   input  logic [7:0]       wr_data_i,
   output logic             wr_busy_o,
   output logic [7:0]       reg_addr_o,
   output logic             reg_stb_o,
   output logic             reg_we_o,
   output logic [7:0]       reg_data_o,
   input  logic [7:0]       reg_data_i,
   input  logic             reg_ack_i,
   input  logic [SEL_W-1:0] rd_sel_i,
   output logic [7:0]       rd_data_o,
   output logic             rd_valid_o,
   output logic             scan_done_o,
   output logic             timeout_o,
   output logic [7:0]       err_cnt_o
);

   localparam int unsigned IdxW = 4;

   typedef enum logic [1:0] {StIdle, StArb, StRd, StWr} state_e;

   state_e              state_q;
   logic [IdxW-1:0]     idx_q;
   logic                in_scan_q;
   logic                pend_q;
   logic [31:0]         per_cnt_q;
   logic [31:0]         tmo_q;
   logic [7:0]          wr_addr_q;
   logic [7:0]          wr_data_q;
   logic [7:0]          bank_q [NUM_REGS];
   logic [NUM_REGS-1:0] valid_q;

   logic [7:0] idx_addr;
   logic       sel_arb, go_wr, go_rd, scan_start, tmo_hit, txn_end, per_wrap;

   always_comb begin
      idx_addr = 8'h00;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (idx_q == IdxW'(i)) idx_addr = ADDR_LIST[8*i +: 8];
      end
   end

   // A latched write wins any arbitration slot, including those between scan entries.
   assign sel_arb    = (state_q == StIdle) || (state_q == StArb);
   assign go_wr      = sel_arb && wr_busy_o && !reg_ack_i;
   assign scan_start = (state_q == StIdle) && !wr_busy_o && pend_q && !reg_ack_i;
   assign go_rd      = (state_q == StArb) && !wr_busy_o && !reg_ack_i;
   assign tmo_hit    = (tmo_q == TIMEOUT - 1);
   assign txn_end    = reg_stb_o && (reg_ack_i || tmo_hit);
   assign per_wrap   = enable_i && (per_cnt_q == PERIOD - 1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         per_cnt_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         if (!enable_i || per_wrap) per_cnt_q <= '0;
         else                       per_cnt_q <= per_cnt_q + 32'd1;
         // New requests beat the clear so a request landing on scan start is not lost.
         if (per_wrap || scan_now_i) pend_q <= 1'b1;
         else if (scan_start)        pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         in_scan_q   <= 1'b0;
         tmo_q       <= '0;
         wr_busy_o   <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         reg_stb_o   <= 1'b0;
         reg_we_o    <= 1'b0;
         reg_addr_o  <= '0;
         reg_data_o  <= '0;
         scan_done_o <= 1'b0;
         timeout_o   <= 1'b0;
         err_cnt_o   <= '0;
         valid_q     <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) bank_q[i] <= 8'hFF;
      end else begin
         scan_done_o <= 1'b0;
         if (wr_req_i && !wr_busy_o) begin
            wr_busy_o <= 1'b1;
            wr_addr_q <= wr_addr_i;
            wr_data_q <= wr_data_i;
         end
         unique case (state_q)
            StIdle, StArb: begin
               if (go_wr) begin
                  state_q    <= StWr;
                  reg_stb_o  <= 1'b1;
                  reg_we_o   <= 1'b1;
                  reg_addr_o <= wr_addr_q;
                  reg_data_o <= wr_data_q;
                  tmo_q      <= '0;
               end else if (scan_start || go_rd) begin
                  state_q    <= StRd;
                  reg_stb_o  <= 1'b1;
                  reg_we_o   <= 1'b0;
                  reg_data_o <= '0;
                  reg_addr_o <= scan_start ? ADDR_LIST[7:0] : idx_addr;
                  tmo_q      <= '0;
                  if (scan_start) begin
                     idx_q     <= '0;
                     in_scan_q <= 1'b1;
                  end
               end
            end
            StRd, StWr: begin
               if (!txn_end) begin
                  tmo_q <= tmo_q + 32'd1;
               end else begin
                  reg_stb_o  <= 1'b0;
                  reg_we_o   <= 1'b0;
                  reg_data_o <= '0;
                  // An ack coinciding with the timeout still counts as a good transfer.
                  if (!reg_ack_i) begin
                     timeout_o <= 1'b1;
                     if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                  end
                  if (state_q == StWr) begin
                     wr_busy_o <= 1'b0;
                     state_q   <= in_scan_q ? StArb : StIdle;
                  end else begin
                     for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (idx_q == IdxW'(i)) begin
                           if (reg_ack_i) bank_q[i] <= reg_data_i;
                           valid_q[i] <= reg_ack_i;
                        end
                     end
                     if (idx_q == IdxW'(NUM_REGS - 1)) begin
                        scan_done_o <= 1'b1;
                        in_scan_q   <= 1'b0;
                        state_q     <= StIdle;
                     end else begin
                        idx_q   <= idx_q + IdxW'(1);
                        state_q <= StArb;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      rd_data_o  = 8'hFF;
      rd_valid_o = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rd_sel_i == SEL_W'(i)) begin
            rd_data_o  = bank_q[i];
            rd_valid_o = valid_q[i];
         end
      end
   end

endmodule

// File: tb/tb_ulpi_reg_scanner.sv
// Bench for ulpi_reg_scanner: a PHY register model answers the register port with random
// latency; expected bank contents come from the model's register file and withheld addresses.
module tb_ulpi_reg_scanner;

   localparam int NR = 4;

   logic       clk, rst, enable, scan_now, wr_req;
   logic [7:0] wr_addr, wr_data;
   logic       wr_busy;
   logic [7:0] reg_addr, reg_wdata;
   logic       reg_stb, reg_we;
   logic [7:0] reg_rdata;
   logic       reg_ack;
   logic [3:0] rd_sel;
   logic [7:0] rd_data;
   logic       rd_valid, scan_done, timeout;
   logic [7:0] err_cnt;

   ulpi_reg_scanner #(.PERIOD(20)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .scan_now_i(scan_now),
      .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_busy_o(wr_busy),
      .reg_addr_o(reg_addr), .reg_stb_o(reg_stb), .reg_we_o(reg_we), .reg_data_o(reg_wdata),
      .reg_data_i(reg_rdata), .reg_ack_i(reg_ack), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
      .rd_valid_o(rd_valid), .scan_done_o(scan_done), .timeout_o(timeout), .err_cnt_o(err_cnt)
   );

   // PHY model state: base contents set by the stimulus, writes recorded by the responder.
   logic [7:0] phy_base [256];
   bit         withhold [256];
   logic [7:0] wr_shadow [256];
   bit         wr_valid [256];
   int         lat_fixed;

   logic [7:0] tq_addr [$];
   bit         tq_we [$];
   logic [7:0] tq_data [$];
   bit         tq_to [$];
   int         start_cyc [$];
   int         done_cnt, unstable, last_to_len, cyc;

   bit         in_txn, t_we;
   int         wait_cnt, cur_lat, hi_len;
   logic [7:0] t_addr, t_data;

   logic [7:0] addrs [NR];
   logic [7:0] exp_bank [NR];
   bit         exp_valid [NR];
   logic [7:0] e3_addr [5];
   bit         e3_we [5];
   int         n_tests = 0, n_fail = 0;
   int         base, tb_i, sb_i;

   function automatic logic [7:0] phy_val(input logic [7:0] a);
      return wr_valid[a] ? wr_shadow[a] : phy_base[a];
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Register-port responder: acks after cur_lat cycles unless the address is withheld.
   initial begin
      reg_ack = 1'b0; reg_rdata = 8'h00; done_cnt = 0; unstable = 0;
      in_txn = 1'b0; last_to_len = 0;
      for (int a = 0; a < 256; a++) wr_valid[a] = 1'b0;
      forever begin
         @(negedge clk);
         if (scan_done === 1'b1) done_cnt++;
         if (rst) begin
            reg_ack = 1'b0;
            in_txn  = 1'b0;
         end else if (reg_ack) begin
            reg_ack   = 1'b0;
            in_txn    = 1'b0;
            reg_rdata = 8'($urandom);
         end else if (reg_stb === 1'b1) begin
            if (!in_txn) begin
               in_txn   = 1'b1;
               wait_cnt = 0;
               hi_len   = 0;
               cur_lat  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(4, 1));
               t_addr   = reg_addr;
               t_we     = reg_we;
               t_data   = reg_wdata;
               if (!reg_we && reg_addr == 8'h04) start_cyc.push_back(cyc);
            end else if (reg_addr !== t_addr || reg_we !== t_we || reg_wdata !== t_data) begin
               unstable++;
            end
            hi_len++;
            wait_cnt++;
            if (!withhold[t_addr] && wait_cnt >= cur_lat) begin
               reg_ack = 1'b1;
               if (t_we) begin
                  wr_shadow[t_addr] = t_data;
                  wr_valid[t_addr]  = 1'b1;
                  reg_rdata = 8'($urandom);
               end else begin
                  reg_rdata = phy_val(t_addr);
               end
               tq_addr.push_back(t_addr);
               tq_we.push_back(t_we);
               tq_data.push_back(t_we ? t_data : reg_rdata);
               tq_to.push_back(1'b0);
            end
         end else if (in_txn) begin
            in_txn      = 1'b0;
            last_to_len = hi_len;
            tq_addr.push_back(t_addr);
            tq_we.push_back(t_we);
            tq_data.push_back(8'h00);
            tq_to.push_back(1'b1);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_now();
      @(posedge clk); #1 scan_now = 1'b1;
      @(posedge clk); #1 scan_now = 1'b0;
   endtask

   task automatic wait_scans(input int n, input int budget, input string tag);
      int b = done_cnt;
      int c = 0;
      while (done_cnt < b + n && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk(tag, done_cnt - b, n);
   endtask

   task automatic wait_stb(input logic [7:0] a, input bit any, input int budget,
                           input string tag);
      int c = 0;
      while (!(reg_stb === 1'b1 && (any || reg_addr === a)) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk(tag, {31'd0, reg_stb}, 32'd1);
   endtask

   task automatic expect_scan();
      for (int i = 0; i < NR; i++) begin
         if (!withhold[addrs[i]]) begin
            exp_bank[i]  = phy_val(addrs[i]);
            exp_valid[i] = 1'b1;
         end else begin
            exp_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic check_bank(input string tag);
      for (int s = 0; s < 6; s++) begin
         int sel = (s == 5) ? 15 : s;
         rd_sel = 4'(sel);
         #1;
         if (sel < NR) begin
            chk($sformatf("%s_data%0d", tag, sel), rd_data, exp_bank[sel]);
            chk($sformatf("%s_valid%0d", tag, sel), rd_valid, exp_valid[sel]);
         end else begin
            chk($sformatf("%s_data%0d", tag, sel), rd_data, 8'hFF);
            chk($sformatf("%s_valid%0d", tag, sel), rd_valid, 1'b0);
         end
      end
   endtask

   task automatic randomize_phy();
      for (int i = 0; i < NR; i++) phy_base[addrs[i]] = 8'($urandom);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; scan_now = 1'b0; wr_req = 1'b0;
      wr_addr = 8'h00; wr_data = 8'h00; rd_sel = 4'd0; lat_fixed = 3;
      addrs[0] = 8'h04; addrs[1] = 8'h05; addrs[2] = 8'h07; addrs[3] = 8'h0A;
      e3_addr[0] = 8'h04; e3_addr[1] = 8'h05; e3_addr[2] = 8'h0A;
      e3_addr[3] = 8'h07; e3_addr[4] = 8'h0A;
      e3_we[0] = 1'b0; e3_we[1] = 1'b0; e3_we[2] = 1'b1; e3_we[3] = 1'b0; e3_we[4] = 1'b0;
      for (int a = 0; a < 256; a++) begin
         phy_base[a] = 8'($urandom);
         withhold[a] = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
         exp_bank[i]  = 8'hFF;
         exp_valid[i] = 1'b0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stb", reg_stb, 1'b0);
      chk("rst_we", reg_we, 1'b0);
      chk("rst_addr", reg_addr, 8'h00);
      chk("rst_wdata", reg_wdata, 8'h00);
      chk("rst_busy", wr_busy, 1'b0);
      chk("rst_done", scan_done, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_err", err_cnt, 8'h00);
      check_bank("rst");
      @(posedge clk); #1 rst = 1'b0;

      // Directed scan with known PHY contents and 3-cycle acks
      phy_base[8'h04] = 8'h24; phy_base[8'h05] = 8'h04;
      phy_base[8'h07] = 8'h00; phy_base[8'h0A] = 8'h15;
      tb_i = tq_addr.size();
      base = done_cnt;
      @(posedge clk); #1 scan_now = 1'b1;
      @(posedge clk); #1 scan_now = 1'b0;
      chk("lat_cycle1_stb", reg_stb, 1'b0);
      @(posedge clk); #1;
      chk("lat_cycle2_stb", reg_stb, 1'b1);
      chk("lat_cycle2_addr", reg_addr, 8'h04);
      wait_scans(1, 300, "t1_done");
      repeat (30) @(posedge clk);
      #1;
      chk("t1_single_done", done_cnt - base, 1);
      chk("t1_ntx", tq_addr.size() - tb_i, NR);
      for (int i = 0; i < NR && tb_i + i < tq_addr.size(); i++) begin
         chk($sformatf("t1_addr%0d", i), tq_addr[tb_i + i], addrs[i]);
         chk($sformatf("t1_we%0d", i), tq_we[tb_i + i], 1'b0);
      end
      expect_scan();
      check_bank("t1");

      // Withheld ack on 07: timeout, old value kept, entry invalid
      withhold[8'h07] = 1'b1;
      lat_fixed = 0;
      randomize_phy();
      tb_i = tq_addr.size();
      pulse_now();
      wait_scans(1, 2000, "t2_done");
      chk("t2_stb_len", last_to_len, 255);
      chk("t2_ntx", tq_addr.size() - tb_i, NR);
      for (int i = 0; i < NR && tb_i + i < tq_addr.size(); i++)
         chk($sformatf("t2_to%0d", i), tq_to[tb_i + i], (i == 2));
      expect_scan();
      check_bank("t2");
      chk("t2_timeout", timeout, 1'b1);
      chk("t2_err", err_cnt, 8'd1);
      withhold[8'h07] = 1'b0;

      // Write request inserted mid-scan; a second request while busy is dropped
      randomize_phy();
      tb_i = tq_addr.size();
      pulse_now();
      wait_stb(8'h05, 1'b0, 100, "t3_on_entry1");
      wr_addr = 8'h0A; wr_data = 8'h06; wr_req = 1'b1;
      @(posedge clk); #1;
      chk("t3_busy", wr_busy, 1'b1);
      wr_addr = 8'h33; wr_data = 8'h77;
      @(posedge clk); #1 wr_req = 1'b0;
      wait_scans(1, 300, "t3_done");
      chk("t3_busy_clear", wr_busy, 1'b0);
      chk("t3_ntx", tq_addr.size() - tb_i, 5);
      for (int i = 0; i < 5 && tb_i + i < tq_addr.size(); i++) begin
         chk($sformatf("t3_addr%0d", i), tq_addr[tb_i + i], e3_addr[i]);
         chk($sformatf("t3_we%0d", i), tq_we[tb_i + i], e3_we[i]);
      end
      if (tb_i + 2 < tq_addr.size()) chk("t3_wdata", tq_data[tb_i + 2], 8'h06);
      expect_scan();
      check_bank("t3");

      // Periodic scans every 20 cycles; enable drops mid-scan and that scan completes
      lat_fixed = 1;
      sb_i = start_cyc.size();
      base = done_cnt;
      @(posedge clk); #1 enable = 1'b1;
      repeat (65) @(posedge clk);
      #1 enable = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("t4_starts", start_cyc.size() - sb_i, 3);
      for (int i = 1; i < 3 && sb_i + i < start_cyc.size(); i++)
         chk($sformatf("t4_gap%0d", i), start_cyc[sb_i + i] - start_cyc[sb_i + i - 1], 20);
      chk("t4_dones", done_cnt - base, 3);

      // Three requests during one scan coalesce into one follow-up scan
      lat_fixed = 4;
      tb_i = tq_addr.size();
      base = done_cnt;
      pulse_now();
      wait_stb(8'h00, 1'b1, 20, "t5_stb");
      repeat (3) begin
         @(posedge clk); #1 scan_now = 1'b1;
         @(posedge clk); #1 scan_now = 1'b0;
      end
      wait_scans(2, 400, "t5_done");
      repeat (60) @(posedge clk);
      #1;
      chk("t5_total_dones", done_cnt - base, 2);
      chk("t5_ntx", tq_addr.size() - tb_i, 2 * NR);

      // Asynchronous reset in the middle of a transaction
      withhold[8'h04] = 1'b1;
      lat_fixed = 0;
      pulse_now();
      wait_stb(8'h04, 1'b0, 20, "t6_stb");
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t6_stb_drop", reg_stb, 1'b0);
      chk("t6_timeout", timeout, 1'b0);
      chk("t6_err", err_cnt, 8'h00);
      chk("t6_busy", wr_busy, 1'b0);
      for (int i = 0; i < NR; i++) begin
         exp_bank[i]  = 8'hFF;
         exp_valid[i] = 1'b0;
      end
      check_bank("t6");
      @(posedge clk); #1 rst = 1'b0;
      withhold[8'h04] = 1'b0;

      // Error counter saturation over back-to-back all-timeout scans
      for (int i = 0; i < NR; i++) withhold[addrs[i]] = 1'b1;
      @(posedge clk); #1 enable = 1'b1;
      wait_scans(63, 70000, "t7_63_scans");
      chk("t7_err_252", err_cnt, 8'd252);
      chk("t7_timeout", timeout, 1'b1);
      wait_scans(2, 3000, "t7_65_scans");
      chk("t7_err_sat", err_cnt, 8'd255);
      enable = 1'b0;

      chk("stb_fields_stable", unstable, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
